// File: rtl/seg_pkg.sv
// Shared constants, code type and code-validity helper for the seven-segment scan controller.
package seg_pkg;
  localparam int NUM_DIG      = 8;
  localparam int CODE_HEX_MAX = 15;
  localparam int CODE_DP_BASE = 20;
  localparam int CODE_DP_MAX  = 35;

  typedef logic [6:0] code_t;

  // Valid codes are plain hex (0-15) or hex with decimal point (20-35).
  function automatic logic code_valid(input code_t code);
    return (int'(code) <= CODE_HEX_MAX) ||
           ((int'(code) >= CODE_DP_BASE) && (int'(code) <= CODE_DP_MAX));
  endfunction
endpackage

// File: rtl/seg_scan_tick.sv
// Per-slot cycle counter: flags the first, last and dead-time cycles of each digit slot.
module seg_scan_tick #(
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic slot_start_o,
  output logic slot_last_o,
  output logic guard_active_o
);
  localparam int            CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GUARD_N = CW'(GUARD);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (run_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign slot_start_o   = (cnt_q == '0);
  assign slot_last_o    = (cnt_q == LAST);
  assign guard_active_o = (cnt_q < GUARD_N);
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit display scanner with shadow/active buffers and frame-aligned commit.
// Optional leading-zero blanking is built when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl import seg_pkg::*; #(
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr_en_i,
  input  logic [2:0]   wr_addr_i,
  input  logic [6:0]   wr_data_i,
  input  logic         commit_i,
  input  logic [7:0]   dig_mask_i,
  output logic [6:0]   digit_o,
  output logic [7:0]   com_o,
  output logic         pending_o,
  output logic         frame_done_o
);
  code_t              shadow_q [NUM_DIG];
  code_t              active_q [NUM_DIG];
  logic [2:0]         slot_q, slot_d;
  logic               pending_q, pending_d;
  logic               started_q;
  logic               frame_seen_q;
  logic               slot_start, slot_last, guard_active;
  logic               frame_end, load_active;
  logic [NUM_DIG-1:0] lzb;
  code_t              cur_code;
  logic               blank;

  seg_scan_tick #(.CLK_DIV(CLK_DIV), .GUARD(GUARD)) u_tick (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .run_i          (started_q),
    .slot_start_o   (slot_start),
    .slot_last_o    (slot_last),
    .guard_active_o (guard_active)
  );

  assign frame_end   = slot_last && (slot_q == 3'(NUM_DIG - 1));
  assign load_active = frame_end && (pending_q || commit_i);
  assign cur_code    = active_q[slot_q];

`ifdef SEG_SCAN_LZB_EN
  logic all_zero;
  // Walk down from the leftmost digit; index 0 is never a leading zero.
  always_comb begin
    all_zero = 1'b1;
    lzb      = '0;
    for (int i = NUM_DIG - 1; i > 0; i--) begin
      all_zero = all_zero && (active_q[i] == '0);
      lzb[i]   = all_zero;
    end
  end
`else
  assign lzb = '0;
`endif

  assign blank = !dig_mask_i[slot_q] || !code_valid(cur_code) || lzb[slot_q];

  always_comb begin
    slot_d    = slot_last ? slot_q + 3'd1 : slot_q;
    pending_d = pending_q;
    if (load_active)   pending_d = 1'b0;
    else if (commit_i) pending_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      started_q    <= 1'b0;
      slot_q       <= '0;
      pending_q    <= 1'b0;
      frame_seen_q <= 1'b0;
      for (int i = 0; i < NUM_DIG; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      started_q <= 1'b1;
      slot_q    <= slot_d;
      pending_q <= pending_d;
      if (frame_end) frame_seen_q <= 1'b1;
      // Non-blocking copy picks up the pre-write shadow on a same-cycle write.
      if (load_active) begin
        for (int i = 0; i < NUM_DIG; i++) active_q[i] <= shadow_q[i];
      end
      if (wr_en_i) shadow_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign digit_o      = cur_code;
  assign com_o        = (!started_q || guard_active || blank) ? 8'hFF : ~(8'b1 << slot_q);
  assign pending_o    = pending_q;
  assign frame_done_o = frame_seen_q && slot_start && (slot_q == '0);
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a cycle-level reference model predicts every output cycle.
module tb_seg_scan_ctrl;
  localparam int CLK_DIV = 8;
  localparam int GUARD   = 2;
  localparam int NDIG    = 8;
  localparam int FRAME   = CLK_DIV * NDIG;
`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB_ON = 1'b1;
`else
  localparam bit LZB_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [6:0] wr_data = '0;
  logic       commit = 1'b0;
  logic [7:0] dig_mask = 8'hFF;
  logic [6:0] digit;
  logic [7:0] com;
  logic       pending, frame_done;

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .GUARD(GUARD)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .commit_i     (commit),
    .dig_mask_i   (dig_mask),
    .digit_o      (digit),
    .com_o        (com),
    .pending_o    (pending),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] com;
    logic [6:0] digit;
    logic       pending;
    logic       frame_done;
    string      tag;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  int    checks = 0;
  int    errors = 0;
  string phase = "init";

  // Reference model: time counted in cycles since scanning began (-1 = not yet started).
  int m_t = -1;
  int m_shadow[NDIG];
  int m_active[NDIG];
  bit m_pending = 1'b0;

  function automatic bit code_ok(input int c);
    return (c <= 15) || (c >= 20 && c <= 35);
  endfunction

  function automatic bit lead_zero(input int idx);
    if (idx == 0) return 1'b0;
    for (int j = idx; j < NDIG; j++) if (m_active[j] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", tag, name, got, want, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict this cycle's outputs, then advance the model over the edge.
  task automatic step(input bit we = 0, input int addr = 0, input int data = 0,
                      input bit cm = 0, input bit rs = 0);
    exp_t e;
    int   slot = 0;
    int   c = 0;
    rst = rs; wr_en = we; wr_addr = 3'(addr); wr_data = 7'(data); commit = cm;
    if (rs) begin
      for (int i = 0; i < NDIG; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
      m_pending = 1'b0;
      m_t = -1;
    end
    e.tag = phase;
    e.pending = m_pending;
    if (m_t < 0) begin
      e.com = 8'hFF; e.digit = 7'(m_active[0]); e.frame_done = 1'b0;
    end else begin
      slot = (m_t / CLK_DIV) % NDIG;
      c = m_t % CLK_DIV;
      e.digit = 7'(m_active[slot]);
      e.frame_done = (m_t > 0) && (m_t % FRAME == 0);
      if (c < GUARD || !dig_mask[slot] || !code_ok(m_active[slot]) || (LZB_ON && lead_zero(slot)))
        e.com = 8'hFF;
      else
        e.com = ~(8'd1 << slot);
    end
    exp_q.push_back(e);
    if (!rs) begin
      if (m_t >= 0 && slot == NDIG - 1 && c == CLK_DIV - 1 && (m_pending || cm)) begin
        m_active = m_shadow;
        m_pending = 1'b0;
      end else if (cm) begin
        m_pending = 1'b1;
      end
      if (we) m_shadow[addr] = data;
      m_t++;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_until(input int slot, input int c);
    for (int n = 0; n < 2 * FRAME; n++) begin
      if (m_t >= 0 && (m_t / CLK_DIV) % NDIG == slot && m_t % CLK_DIV == c) return;
      step();
    end
    checks++; errors++;
    $display("FAIL run_until: slot %0d cycle %0d not reached, model time %0d", slot, c, m_t);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check(mon_e.tag, "com", 32'(com), 32'(mon_e.com));
      check(mon_e.tag, "digit", 32'(digit), 32'(mon_e.digit));
      check(mon_e.tag, "pending", 32'(pending), 32'(mon_e.pending));
      check(mon_e.tag, "frame_done", 32'(frame_done), 32'(mon_e.frame_done));
    end
  end

  initial begin
    bit we, cm, rs;
    @(posedge clk); #1;
    phase = "reset";
    repeat (3) step(0, 0, 0, 0, 1);
    step();

    phase = "scan";
    for (int i = 0; i < NDIG; i++) step(1, i, i, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (2 * FRAME) step();

    phase = "tear";
    run_until(3, 0);
    step(1, 3, 9, 0, 0);
    run_until(5, 0);
    step(0, 0, 0, 1, 0);
    repeat (2 * FRAME) step();

    phase = "blank";
    dig_mask = 8'hEF;
    step(1, 2, 17, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (2 * FRAME) step();
    dig_mask = 8'hFF;

    phase = "collide";
    step(0, 0, 0, 1, 0);
    run_until(7, CLK_DIV - 1);
    step(1, 0, 25, 0, 0);
    repeat (FRAME) step();
    step(0, 0, 0, 1, 0);
    repeat (2 * FRAME) step();

    phase = "reset_mid";
    step(0, 0, 0, 1, 0);
    run_until(4, 5);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step();
    repeat (FRAME + 4) step();

    phase = "lzb";
    for (int i = 0; i < NDIG; i++) step(1, i, (i == 5) ? 20 : 0, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (2 * FRAME) step();

    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      if (n % 97 == 0) dig_mask = 8'($urandom);
      we = ($urandom_range(0, 3) == 0);
      cm = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 499) == 0);
      step(we, int'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 35)),
           cm, rs);
    end
    dig_mask = 8'hFF;
    phase = "lzb_tail";
    for (int i = 0; i < NDIG; i++) step(1, i, 0, 0, 0);
    step(1, 2, 3, 1, 0);
    repeat (2 * FRAME) step();

    @(negedge clk); #1;
    check("end", "queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
